// File: rtl/cla_arb_pkg.sv
// rtl/cla_arb_pkg.sv - shared constants for the round-robin shared-adder arbiter
// Purpose: datapath width, default requester count/ID width and FSM state codes.
// Ports: none (package).
package cla_arb_pkg;
    localparam int DATA_W      = 64;
    localparam int NUM_REQ_DEF = 4;
    localparam int ID_W_DEF    = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
endpackage

// File: rtl/cla_64bit.sv
// rtl/cla_64bit.sv - 64-bit carry-lookahead adder built from 4-bit lookahead groups
// Purpose: sum = a + b + cin mod 2^DATA_W, purely combinational.
// Ports: a, b (operands), cin (carry-in), sum (result).
module cla_64bit
    import cla_arb_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum
);
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] p;
    logic [3:0]        gn;
    logic [3:0]        pn;
    logic [3:0]        c;
    logic              gc;

    assign g = a & b;
    assign p = a ^ b;

    // Each group resolves its internal carries from the incoming group carry in
    // two gate levels; the group carry-out uses the group generate/propagate.
    always_comb begin
        sum = '0;
        gn  = '0;
        pn  = '0;
        c   = '0;
        gc  = cin;
        for (int k = 0; k < DATA_W / 4; k++) begin
            gn   = g[4*k +: 4];
            pn   = p[4*k +: 4];
            c[0] = gc;
            c[1] = gn[0] | (pn[0] & gc);
            c[2] = gn[1] | (pn[1] & gn[0]) | (pn[1] & pn[0] & gc);
            c[3] = gn[2] | (pn[2] & gn[1]) | (pn[2] & pn[1] & gn[0])
                 | (pn[2] & pn[1] & pn[0] & gc);
            sum[4*k +: 4] = pn ^ c;
            gc = gn[3] | (pn[3] & gn[2]) | (pn[3] & pn[2] & gn[1])
               | (pn[3] & pn[2] & pn[1] & gn[0]) | ((&pn) & gc);
        end
    end
endmodule

// File: rtl/cla_rr_arbiter.sv
// rtl/cla_rr_arbiter.sv - combinational round-robin grant search
// Purpose: pick the first valid requester at or above rr_ptr_i, wrapping to 0.
// Ports: req_valid_i, rr_ptr_i in; grant_oh_o (one-hot), grant_idx_o, grant_any_o out.
module cla_rr_arbiter
    import cla_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = ID_W_DEF
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [ID_W-1:0]    rr_ptr_i,
    output logic [NUM_REQ-1:0] grant_oh_o,
    output logic [ID_W-1:0]    grant_idx_o,
    output logic               grant_any_o
);
    int cand;

    always_comb begin
        grant_oh_o  = '0;
        grant_idx_o = '0;
        grant_any_o = 1'b0;
        cand        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(rr_ptr_i) + k) % NUM_REQ;
            if (!grant_any_o && req_valid_i[cand]) begin
                grant_any_o      = 1'b1;
                grant_oh_o[cand] = 1'b1;
                grant_idx_o      = ID_W'(cand);
            end
        end
    end
endmodule

// File: rtl/cla_add_arbiter.sv
// rtl/cla_add_arbiter.sv - round-robin arbiter sharing one 64-bit CLA among requesters
// Purpose: IDLE accepts one request, EXEC adds from the operand registers,
//   RESP presents the tagged result until resp_ready.
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_a/req_b/req_cin per requester;
//   resp_valid/resp_ready/resp_sum/resp_id; resp_cout only when CLA_ARB_COUT_EN is defined.
module cla_add_arbiter
    import cla_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int ID_W    = ID_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]        req_cin,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_W-1:0]         resp_sum,
    output logic [ID_W-1:0]           resp_id
`ifdef CLA_ARB_COUT_EN
    ,
    output logic                      resp_cout
`endif
);
    logic [1:0]        state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic              op_cin_q, op_cin_d;
    logic [ID_W-1:0]   op_id_q, op_id_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_sum_q, resp_sum_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;
`ifdef CLA_ARB_COUT_EN
    logic              resp_cout_q, resp_cout_d;
`endif

    logic [NUM_REQ-1:0] grant_oh;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_any;
    logic [DATA_W-1:0]  sel_a;
    logic [DATA_W-1:0]  sel_b;
    logic               sel_cin;
    logic [DATA_W-1:0]  add_sum;

    cla_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req_valid_i (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .grant_oh_o  (grant_oh),
        .grant_idx_o (grant_idx),
        .grant_any_o (grant_any)
    );

    // The adder only ever sees the operand registers, so requester inputs may
    // change freely once the handshake is done.
    cla_64bit u_add (
        .a   (op_a_q),
        .b   (op_b_q),
        .cin (op_cin_q),
        .sum (add_sum)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                sel_a = req_a[DATA_W*i +: DATA_W];
                sel_b = req_b[DATA_W*i +: DATA_W];
            end
        end
    end

    assign sel_cin   = |(req_cin & grant_oh);
    assign req_ready = (state_q == ST_IDLE) ? grant_oh : '0;

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_cin_d     = op_cin_q;
        op_id_d      = op_id_q;
        resp_valid_d = resp_valid_q;
        resp_sum_d   = resp_sum_q;
        resp_id_d    = resp_id_q;
`ifdef CLA_ARB_COUT_EN
        resp_cout_d  = resp_cout_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    op_a_d   = sel_a;
                    op_b_d   = sel_b;
                    op_cin_d = sel_cin;
                    op_id_d  = grant_idx;
                    rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                resp_sum_d   = add_sum;
                resp_id_d    = op_id_q;
`ifdef CLA_ARB_COUT_EN
                // Carry out of the top bit recovered from the operand and sum MSBs.
                resp_cout_d  = (op_a_q[DATA_W-1] & op_b_q[DATA_W-1])
                             | ((op_a_q[DATA_W-1] ^ op_b_q[DATA_W-1]) & ~add_sum[DATA_W-1]);
`endif
                resp_valid_d = 1'b1;
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                if (resp_valid_q && resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_cin_q     <= 1'b0;
            op_id_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_sum_q   <= '0;
            resp_id_q    <= '0;
`ifdef CLA_ARB_COUT_EN
            resp_cout_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_cin_q     <= op_cin_d;
            op_id_q      <= op_id_d;
            resp_valid_q <= resp_valid_d;
            resp_sum_q   <= resp_sum_d;
            resp_id_q    <= resp_id_d;
`ifdef CLA_ARB_COUT_EN
            resp_cout_q  <= resp_cout_d;
`endif
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_sum   = resp_sum_q;
    assign resp_id    = resp_id_q;
`ifdef CLA_ARB_COUT_EN
    assign resp_cout  = resp_cout_q;
`endif
endmodule

// File: tb/tb_cla_add_arbiter.sv
// tb/tb_cla_add_arbiter.sv - scoreboard bench for the shared-adder round-robin arbiter
module tb_cla_add_arbiter;
    localparam int N = 4;
    localparam int W = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_cin;
    logic           resp_valid;
    logic           resp_ready;
    logic [W-1:0]   resp_sum;
    logic [1:0]     resp_id;
`ifdef CLA_ARB_COUT_EN
    logic           resp_cout;
`endif

    always #5 clk = ~clk;

    cla_add_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_id    (resp_id)
`ifdef CLA_ARB_COUT_EN
        ,
        .resp_cout  (resp_cout)
`endif
    );

    typedef struct {
        logic [W-1:0] sum;
        logic [1:0]   id;
        logic         cout;
    } exp_t;

    exp_t       sb_q[$];
    int         checks   = 0;
    int         failures = 0;

    // Reference model: pending request per requester plus the arbiter phase
    // (0 = idle, 1 = computing, 2 = presenting) and the round-robin start point.
    logic [W-1:0] cur_a [N];
    logic [W-1:0] cur_b [N];
    bit           cur_v [N];
    bit           cur_c [N];
    int           m_state = 0;
    int           m_ptr   = 0;
    int           mode    = 0;
    bit           rr_drive = 1'b1;
    int           rr_pct   = 100;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rand64();
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return '0;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic new_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input bit c);
        cur_v[i] = 1'b1;
        cur_a[i] = a;
        cur_b[i] = b;
        cur_c[i] = c;
    endtask

    task automatic gen();
        for (int i = 0; i < N; i++) begin
            if (mode == 1 && !cur_v[i]) begin
                new_req(i, rand64(), rand64(), 1'($urandom_range(0, 1)));
            end else if (mode == 2) begin
                if (cur_v[i] && $urandom_range(0, 19) == 0)
                    cur_v[i] = 1'b0;
                else if (!cur_v[i] && $urandom_range(0, 2) == 0)
                    new_req(i, rand64(), rand64(), 1'($urandom_range(0, 1)));
            end
        end
    endtask

    task automatic step(input bit r);
        logic [N-1:0] exp_ready;
        logic [W:0]   full;
        exp_t         e;
        int           g;
        @(negedge clk);
        gen();
        rst = r;
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = cur_v[i];
            req_a[W*i +: W]    = cur_a[i];
            req_b[W*i +: W]    = cur_b[i];
            req_cin[i]         = cur_c[i];
        end
        resp_ready = r ? 1'b0 : (rr_drive && ($urandom_range(0, 99) < rr_pct));
        #1;
        if (r) begin
            if (m_state != 0 && sb_q.size() > 0) sb_q.pop_back();
            m_state = 0;
            m_ptr   = 0;
        end else begin
            exp_ready = '0;
            chk("resp_valid", W'(resp_valid), W'(m_state == 2));
            if (m_state == 2 && sb_q.size() > 0) begin
                chk("hold_sum", resp_sum, sb_q[0].sum);
                chk("hold_id", W'(resp_id), W'(sb_q[0].id));
            end
            case (m_state)
                0: begin
                    g = -1;
                    for (int k = 0; k < N; k++)
                        if (g < 0 && cur_v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
                    if (g >= 0) begin
                        exp_ready[g] = 1'b1;
                        full   = {1'b0, cur_a[g]} + {1'b0, cur_b[g]} + {{W{1'b0}}, cur_c[g]};
                        e.sum  = full[W-1:0];
                        e.id   = 2'(g);
                        e.cout = full[W];
                        sb_q.push_back(e);
                        cur_v[g] = 1'b0;
                        m_ptr    = (g + 1) % N;
                        m_state  = 1;
                    end
                end
                1:       m_state = 2;
                default: if (resp_ready) m_state = 0;
            endcase
            chk("req_ready", W'(req_ready), W'(exp_ready));
        end
    endtask

    task automatic run_idle(input int max);
        int n = 0;
        while ((m_state != 0 || sb_q.size() != 0 || cur_v[0] || cur_v[1] || cur_v[2] || cur_v[3])
               && n < max) begin
            step(1'b0);
            n++;
        end
        if (n >= max) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d pending required=0", sb_q.size());
        end
    endtask

    // Monitor: pops the oldest expectation whenever the DUT completes a response handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && resp_valid && resp_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL resp_unexpected actual=%0h required=none", resp_sum);
                end else begin
                    e = sb_q.pop_front();
                    chk("resp_sum", resp_sum, e.sum);
                    chk("resp_id", W'(resp_id), W'(e.id));
`ifdef CLA_ARB_COUT_EN
                    chk("resp_cout", W'(resp_cout), W'(e.cout));
`endif
                end
            end
        end
    end

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_cin    = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            cur_v[i] = 1'b0; cur_c[i] = 1'b0; cur_a[i] = '0; cur_b[i] = '0;
        end

        step(1'b1);
        step(1'b1);
        chk("rst_resp_valid", W'(resp_valid), '0);
        chk("rst_resp_sum", resp_sum, '0);
        chk("rst_resp_id", W'(resp_id), '0);
        chk("rst_req_ready", W'(req_ready), '0);

        // single request from requester 0
        new_req(0, 64'd1, 64'd2, 1'b0);
        run_idle(20);

        // all requesters held valid after reset: round-robin from 0
        step(1'b1);
        mode = 1;
        repeat (16) step(1'b0);
        mode = 0;
        for (int i = 0; i < N; i++) cur_v[i] = 1'b0;
        run_idle(20);

        // wrap-around and carry-in corners
        new_req(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        run_idle(20);
        new_req(1, 64'd0, 64'd0, 1'b1);
        run_idle(20);

        // response back-pressure with other requesters waiting
        rr_drive = 1'b0;
        new_req(3, rand64(), rand64(), 1'b0);
        repeat (3) step(1'b0);
        new_req(0, rand64(), rand64(), 1'b1);
        new_req(1, rand64(), rand64(), 1'b0);
        repeat (5) step(1'b0);
        rr_drive = 1'b1;
        run_idle(40);

        // reset while computing: operation dropped, search restarts at 0
        new_req(1, rand64(), rand64(), 1'b1);
        step(1'b0);
        step(1'b1);
        for (int i = 0; i < N; i++) new_req(i, rand64(), rand64(), 1'($urandom_range(0, 1)));
        run_idle(40);

        // randomized traffic with random back-pressure
        mode   = 2;
        rr_pct = 70;
        repeat (600) step(1'b0);
        mode   = 0;
        rr_pct = 100;
        run_idle(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
